// File: rtl/cw305_crypto_seq.sv
// cw305_crypto_seq: crypto-core sequencer in the crypto_clk domain.
// Trigger window with pre/post extension, timeout, cycle count, channel sweep.

module cw305_crypto_seq #(
    parameter int pSEL_WIDTH = 1,
    parameter int pCYC_WIDTH = 32,
    parameter int pTO_WIDTH  = 16,
    parameter int pEXT_WIDTH = 8,
    localparam int pCHANNELS = 2 ** pSEL_WIDTH
) (
    input  logic                  crypto_clk,
    input  logic                  reset_i,
    input  logic                  I_start,
    input  logic                  I_abort,
    input  logic                  I_mode,
    input  logic [pSEL_WIDTH-1:0] I_chan_sel,
    input  logic [pTO_WIDTH-1:0]  I_timeout,
    input  logic [pEXT_WIDTH-1:0] I_trig_pre,
    input  logic [pEXT_WIDTH-1:0] I_trig_post,
    output logic [pCHANNELS-1:0]  O_start,
    input  logic [pCHANNELS-1:0]  I_ready,
    input  logic [pCHANNELS-1:0]  I_busy,
    input  logic [pCHANNELS-1:0]  I_done,
    output logic                  O_trigger,
    output logic                  O_busy,
    output logic                  O_done,
    output logic                  O_timeout,
    output logic [pCYC_WIDTH-1:0] O_cycle_count,
    output logic [pSEL_WIDTH-1:0] O_chan
);

    localparam logic [pTO_WIDTH-1:0]  TO_ONE   = pTO_WIDTH'(1);
    localparam logic [pEXT_WIDTH-1:0] EXT_ONE  = pEXT_WIDTH'(1);
    localparam logic [pCYC_WIDTH-1:0] CYC_ONE  = pCYC_WIDTH'(1);
    localparam logic [pSEL_WIDTH-1:0] CHAN_ONE = pSEL_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_READY,
        ST_PRE,
        ST_START,
        ST_RUN,
        ST_POST,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;

    // Configuration captured when a request is accepted.
    logic                  mode_q, mode_d;
    logic [pTO_WIDTH-1:0]  tmo_q, tmo_d;
    logic [pEXT_WIDTH-1:0] pre_q, pre_d;
    logic [pEXT_WIDTH-1:0] post_q, post_d;

    // Sequencing counters.
    logic [pEXT_WIDTH-1:0] ext_q, ext_d;
    logic [pTO_WIDTH-1:0]  tcnt_q, tcnt_d;
    logic [pCYC_WIDTH-1:0] cyc_q, cyc_d;

    // Registered outputs.
    logic [pCYC_WIDTH-1:0] ccount_q, ccount_d;
    logic [pSEL_WIDTH-1:0] chan_q, chan_d;
    logic [pCHANNELS-1:0]  start_q, start_d;
    logic                  trig_q, trig_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tout_q, tout_d;

    // Decoded views of the addressed core.
    logic                  chan_ready;
    logic                  chan_fin;
    logic                  to_hit;
    logic                  sweep_next;
    logic [pTO_WIDTH-1:0]  tcnt_inc;
    logic [pCYC_WIDTH-1:0] cyc_inc;
    logic [pCHANNELS-1:0]  start_onehot;

    // Status of the addressed core and saturating counter increments.
    always_comb begin
        chan_ready   = I_ready[chan_q];
        chan_fin     = I_done[chan_q] & ~I_busy[chan_q];
        to_hit       = (tmo_q != '0) && (tcnt_q == tmo_q - TO_ONE);
        sweep_next   = mode_q & ~(&chan_q);
        tcnt_inc     = (&tcnt_q) ? tcnt_q : tcnt_q + TO_ONE;
        cyc_inc      = (&cyc_q) ? cyc_q : cyc_q + CYC_ONE;
        start_onehot = '0;
        start_onehot[chan_q] = 1'b1;
    end

    // Next-state and next-output logic; abort overrides everything else.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        tmo_d    = tmo_q;
        pre_d    = pre_q;
        post_d   = post_q;
        ext_d    = ext_q;
        tcnt_d   = tcnt_q;
        cyc_d    = cyc_q;
        ccount_d = ccount_q;
        chan_d   = chan_q;
        start_d  = '0;
        trig_d   = trig_q;
        tout_d   = tout_q;

        if (state_q == ST_START || state_q == ST_RUN) begin
            cyc_d = cyc_inc;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (I_start) begin
                    mode_d  = I_mode;
                    tmo_d   = I_timeout;
                    pre_d   = I_trig_pre;
                    post_d  = I_trig_post;
                    chan_d  = I_mode ? '0 : I_chan_sel;
                    tout_d  = 1'b0;
                    tcnt_d  = '0;
                    state_d = ST_WAIT_READY;
                end
            end

            ST_WAIT_READY: begin
                if (to_hit) begin
                    tout_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (chan_ready) begin
                    trig_d = 1'b1;
                    if (pre_q == '0) begin
                        start_d = start_onehot;
                        cyc_d   = '0;
                        state_d = ST_START;
                    end else begin
                        ext_d   = pre_q - EXT_ONE;
                        state_d = ST_PRE;
                    end
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end

            ST_PRE: begin
                if (ext_q == '0) begin
                    start_d = start_onehot;
                    cyc_d   = '0;
                    state_d = ST_START;
                end else begin
                    ext_d = ext_q - EXT_ONE;
                end
            end

            ST_START: begin
                tcnt_d  = '0;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (to_hit) begin
                    tout_d  = 1'b1;
                    trig_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (tcnt_q != '0 && chan_fin) begin
                    ccount_d = cyc_q;
                    if (post_q == '0) begin
                        trig_d = 1'b0;
                        if (sweep_next) begin
                            chan_d  = chan_q + CHAN_ONE;
                            tcnt_d  = '0;
                            state_d = ST_WAIT_READY;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        ext_d   = post_q - EXT_ONE;
                        state_d = ST_POST;
                    end
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end

            ST_POST: begin
                if (ext_q == '0) begin
                    trig_d = 1'b0;
                    if (sweep_next) begin
                        chan_d  = chan_q + CHAN_ONE;
                        tcnt_d  = '0;
                        state_d = ST_WAIT_READY;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    ext_d = ext_q - EXT_ONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE && I_abort) begin
            state_d  = ST_IDLE;
            trig_d   = 1'b0;
            start_d  = '0;
            tout_d   = tout_q;
            ccount_d = ccount_q;
            chan_d   = chan_q;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, captured configuration, counters and registered outputs.
    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            tmo_q    <= '0;
            pre_q    <= '0;
            post_q   <= '0;
            ext_q    <= '0;
            tcnt_q   <= '0;
            cyc_q    <= '0;
            ccount_q <= '0;
            chan_q   <= '0;
            start_q  <= '0;
            trig_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            tmo_q    <= tmo_d;
            pre_q    <= pre_d;
            post_q   <= post_d;
            ext_q    <= ext_d;
            tcnt_q   <= tcnt_d;
            cyc_q    <= cyc_d;
            ccount_q <= ccount_d;
            chan_q   <= chan_d;
            start_q  <= start_d;
            trig_q   <= trig_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tout_q   <= tout_d;
        end
    end

    assign O_start       = start_q;
    assign O_trigger     = trig_q;
    assign O_busy        = busy_q;
    assign O_done        = done_q;
    assign O_timeout     = tout_q;
    assign O_cycle_count = ccount_q;
    assign O_chan        = chan_q;

endmodule

// File: tb/tb_cw305_crypto_seq.sv
// tb_cw305_crypto_seq: randomized bench for cw305_crypto_seq.
// Reactive core models plus an event-timeline reference of each sequence.

module tb_cw305_crypto_seq;

    localparam int SEL   = 1;
    localparam int CH    = 2 ** SEL;
    localparam int CW    = 32;
    localparam int TW    = 16;
    localparam int EW    = 8;
    localparam int MAXL  = 1024;
    localparam int BIG   = 1 << 20;
    localparam int BUSYB = CH;
    localparam int DONEB = CH + 1;
    localparam int TRIGB = CH + 2;

    logic          crypto_clk = 1'b0;
    logic          reset_i;
    logic          I_start;
    logic          I_abort;
    logic          I_mode;
    logic [SEL-1:0] I_chan_sel;
    logic [TW-1:0] I_timeout;
    logic [EW-1:0] I_trig_pre;
    logic [EW-1:0] I_trig_post;
    logic [CH-1:0] O_start;
    logic [CH-1:0] I_ready;
    logic [CH-1:0] I_busy;
    logic [CH-1:0] I_done;
    logic          O_trigger;
    logic          O_busy;
    logic          O_done;
    logic          O_timeout;
    logic [CW-1:0] O_cycle_count;
    logic [SEL-1:0] O_chan;

    cw305_crypto_seq #(
        .pSEL_WIDTH(SEL),
        .pCYC_WIDTH(CW),
        .pTO_WIDTH (TW),
        .pEXT_WIDTH(EW)
    ) dut (
        .crypto_clk   (crypto_clk),
        .reset_i      (reset_i),
        .I_start      (I_start),
        .I_abort      (I_abort),
        .I_mode       (I_mode),
        .I_chan_sel   (I_chan_sel),
        .I_timeout    (I_timeout),
        .I_trig_pre   (I_trig_pre),
        .I_trig_post  (I_trig_post),
        .O_start      (O_start),
        .I_ready      (I_ready),
        .I_busy       (I_busy),
        .I_done       (I_done),
        .O_trigger    (O_trigger),
        .O_busy       (O_busy),
        .O_done       (O_done),
        .O_timeout    (O_timeout),
        .O_cycle_count(O_cycle_count),
        .O_chan       (O_chan)
    );

    always #5 crypto_clk = ~crypto_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // core models: start cycle, end-of-busy cycle, latency, ready enable
    int st_cyc[CH];
    int st_end[CH];
    int lat[CH];
    bit rmask[CH];
    int rtime;

    // expected per-cycle {trigger, done, busy, start} from accept cycle
    logic [CH+2:0] expv[MAXL];
    int e_cc;
    int e_to;
    int e_chan;
    int prev_cc;
    int prev_to;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cores();
        for (int c = 0; c < CH; c++) begin
            I_busy[c]  = (cyc >= st_cyc[c] + 2) && (cyc < st_end[c]);
            I_done[c]  = ~I_busy[c];
            I_ready[c] = rmask[c] && (cyc >= rtime);
        end
    endtask

    task automatic tick();
        @(posedge crypto_clk);
        #1;
        cyc++;
        for (int c = 0; c < CH; c++) begin
            if (O_start[c] === 1'b1) begin
                st_cyc[c] = cyc;
                st_end[c] = cyc + lat[c];
            end
        end
        drive_cores();
    endtask

    task automatic scramble();
        I_mode      = 1'($urandom_range(0, 1));
        I_chan_sel  = SEL'($urandom_range(0, CH - 1));
        I_timeout   = TW'($urandom_range(0, 50));
        I_trig_pre  = EW'($urandom_range(0, 9));
        I_trig_post = EW'($urandom_range(0, 9));
    endtask

    task automatic mark_trig(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) expv[k][TRIGB] = 1'b1;
    endtask

    // Timeline of one request: ready, trigger rise, start, completion,
    // trigger fall, next channel or DONE; timeout and abort cut it short.
    task automatic model(input int a, input bit mode, input int chan,
                         input int pre, input int post, input int tmo,
                         input bit abrt, output int dk, output int abk);
        int w, r, s, d, ch, n, hi;
        for (int i = 0; i < MAXL; i++) expv[i] = '0;
        e_cc   = prev_cc;
        e_to   = 0;
        e_chan = chan;
        w      = a + 1;
        abk    = 0;
        n      = mode ? CH : 1;
        for (int i = 0; i < n; i++) begin
            ch     = mode ? i : chan;
            e_chan = ch;
            r = rmask[ch] ? ((w > rtime) ? w : rtime) : BIG;
            if (tmo != 0 && r - w >= tmo - 1) begin
                w    = w + tmo;
                e_to = 1;
                break;
            end
            s = r + 1 + pre;
            expv[s - a][ch] = 1'b1;
            if (tmo != 0 && lat[ch] >= tmo) begin
                mark_trig(r + 1 - a, s + tmo - a);
                w    = s + tmo + 1;
                e_to = 1;
                break;
            end
            d = s + lat[ch];
            if (abrt) begin
                mark_trig(r + 1 - a, d - a);
                abk = d - a;
                break;
            end
            e_cc = lat[ch];
            mark_trig(r + 1 - a, d + post - a);
            w = d + post + 1;
        end
        dk = w - a;
        hi = abrt ? abk : dk;
        for (int k = 1; k <= hi; k++) expv[k][BUSYB] = 1'b1;
        if (!abrt) expv[dk][DONEB] = 1'b1;
    endtask

    task automatic run_seq(input bit mode, input int chan, input int pre,
                           input int post, input int tmo, input int l0,
                           input int l1, input bit m0, input bit m1,
                           input int rdly, input bit abrt, input bit stray);
        int a, dk, abk, lk, last;
        tick();
        a        = cyc;
        lat[0]   = l0;
        lat[1]   = l1;
        rmask[0] = m0;
        rmask[1] = m1;
        rtime    = a + rdly;
        drive_cores();
        model(a, mode, chan, pre, post, tmo, abrt, dk, abk);
        lk   = abrt ? abk + 1 : dk;
        last = abrt ? abk : dk;
        check("idle", {O_trigger, O_done, O_busy, O_start}, 0);
        check("cc_hold", O_cycle_count, prev_cc);
        check("to_hold", O_timeout, prev_to);
        I_start     = 1'b1;
        I_abort     = 1'b0;
        I_mode      = mode;
        I_chan_sel  = SEL'(chan);
        I_timeout   = TW'(tmo);
        I_trig_pre  = EW'(pre);
        I_trig_post = EW'(post);
        for (int k = 1; k <= lk; k++) begin
            tick();
            I_start = 1'b0;
            I_abort = 1'b0;
            check($sformatf("vec+%0d", k),
                  {O_trigger, O_done, O_busy, O_start}, expv[k]);
            if (k == 1) check("to_clr", O_timeout, 0);
            if (k < lk) scramble();
            if (stray && k <= last &&
                ($urandom_range(0, 3) == 0 || k == last)) I_start = 1'b1;
            if (abrt && k == abk) I_abort = 1'b1;
        end
        check("cc", O_cycle_count, e_cc);
        check("tout", O_timeout, e_to);
        check("chan", O_chan, e_chan);
        prev_cc = e_cc;
        prev_to = e_to;
    endtask

    task automatic reset_mid();
        tick();
        lat[0]      = 20;
        rmask[0]    = 1'b1;
        rtime       = cyc;
        drive_cores();
        I_start     = 1'b1;
        I_mode      = 1'b0;
        I_chan_sel  = '0;
        I_timeout   = '0;
        I_trig_pre  = '0;
        I_trig_post = '0;
        tick();
        I_start = 1'b0;
        repeat (6) tick();
        check("run_busy", {O_trigger, O_busy}, 2'b11);
        #2 reset_i = 1'b1;
        #1;
        check("rst_mid", {O_trigger, O_done, O_busy, O_start, O_timeout,
                          O_cycle_count, O_chan}, 0);
        #1 reset_i = 1'b0;
        prev_cc = 0;
        prev_to = 0;
    endtask

    initial begin
        reset_i     = 1'b1;
        I_start     = 1'b0;
        I_abort     = 1'b0;
        I_mode      = 1'b0;
        I_chan_sel  = '0;
        I_timeout   = '0;
        I_trig_pre  = '0;
        I_trig_post = '0;
        rtime       = 0;
        prev_cc     = 0;
        prev_to     = 0;
        for (int c = 0; c < CH; c++) begin
            st_cyc[c] = -BIG;
            st_end[c] = 0;
            lat[c]    = 2;
            rmask[c]  = 1'b0;
        end
        drive_cores();
        repeat (2) @(posedge crypto_clk);
        #1;
        check("rst_out", {O_trigger, O_done, O_busy, O_start, O_timeout,
                          O_cycle_count, O_chan}, 0);
        @(negedge crypto_clk);
        reset_i = 1'b0;

        // single ch1, latency 10, no extension
        run_seq(0, 1, 0, 0, 0, 5, 10, 1, 1, 0, 0, 1);
        // pre 3, post 5
        run_seq(0, 1, 3, 5, 0, 5, 10, 1, 1, 2, 0, 1);
        // sweep, latencies 7 and 12
        run_seq(1, 0, 0, 0, 0, 7, 12, 1, 1, 0, 0, 1);
        // ready never rises, timeout 20
        run_seq(0, 0, 0, 0, 20, 9, 9, 0, 1, 0, 0, 1);
        // next request clears the timeout flag
        run_seq(0, 0, 1, 1, 0, 6, 6, 1, 1, 0, 0, 0);
        // run timeout boundary: latency equal to and one below the limit
        run_seq(0, 1, 0, 2, 8, 8, 8, 1, 1, 0, 0, 0);
        run_seq(0, 1, 0, 2, 8, 7, 7, 1, 1, 0, 0, 0);
        // abort together with completion
        run_seq(0, 0, 2, 3, 0, 9, 9, 1, 1, 1, 1, 1);
        // reset in RUN
        reset_mid();
        run_seq(1, 1, 1, 0, 0, 2, 3, 1, 1, 3, 0, 1);

        for (int it = 0; it < 40; it++) begin
            int tmo;
            bit m0;
            bit m1;
            bit ab;
            tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
            m0  = (tmo == 0) || ($urandom_range(0, 5) != 0);
            m1  = (tmo == 0) || ($urandom_range(0, 5) != 0);
            ab  = (tmo == 0) && ($urandom_range(0, 7) == 0);
            run_seq(1'($urandom_range(0, 1)), int'($urandom_range(0, CH - 1)),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                    tmo, int'($urandom_range(2, 25)),
                    int'($urandom_range(2, 25)), m0, m1,
                    int'($urandom_range(0, 6)), ab, 1'b1);
        end

        tick();
        I_start = 1'b0;
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cw305_crypto_seq.md
Name: cw305_crypto_seq

Overview:
- Parametrised crypto-core sequencer in the crypto_clk domain, between the register block's start/ready/done/busy handshake and 2**pSEL_WIDTH crypto cores.
- Replaces the fixed "trigger = core busy" glue with:
  - a programmable trigger window (pre/post extension);
  - a timeout;
  - start-to-done cycle measurement;
  - a sweep mode that runs every channel back-to-back under one request.

Parameters:
- pSEL_WIDTH, 1, channel select width; pCHANNELS = 2**pSEL_WIDTH (derived localparam).
- pCYC_WIDTH, 32, width of the cycle counter.
- pTO_WIDTH, 16, width of the timeout setting.
- pEXT_WIDTH, 8, width of the pre/post trigger extension settings.

Ports:
- crypto_clk  in  1  block clock
- reset_i  in  1  asynchronous, active-high reset
- I_start  in  1  one-cycle request pulse, already synchronous to crypto_clk
- I_abort  in  1  level; forces return to IDLE
- I_mode  in  1  0 = single channel, 1 = sweep channels 0..pCHANNELS-1
- I_chan_sel  in  pSEL_WIDTH  channel for single mode
- I_timeout  in  pTO_WIDTH  max cycles in WAIT_READY/RUN; 0 disables
- I_trig_pre  in  pEXT_WIDTH  trigger-to-start lead, in cycles
- I_trig_post  in  pEXT_WIDTH  trigger hold after done, in cycles
- O_start  out  pCHANNELS  one-hot start pulse per core
- I_ready  in  pCHANNELS  per-core ready
- I_busy  in  pCHANNELS  per-core busy
- I_done  in  pCHANNELS  per-core done (level)
- O_trigger  out  1  capture trigger to tio_trigger
- O_busy  out  1  sequence in progress
- O_done  out  1  one-cycle sequence-complete pulse
- O_timeout  out  1  sticky timeout flag
- O_cycle_count  out  pCYC_WIDTH  start-to-done cycles of the most recently completed channel
- O_chan  out  pSEL_WIDTH  channel currently/last addressed

Behaviour:
- Reset (async, reset_i=1):
  - state IDLE;
  - all outputs 0, including O_cycle_count, O_timeout and O_chan.
- Config latch:
  - I_mode, I_chan_sel, I_timeout, I_trig_pre and I_trig_post are latched in the accept cycle.
  - Changes to these inputs mid-sequence have no effect.
- States: IDLE, WAIT_READY, PRE, START, RUN, POST, DONE.
- IDLE:
  - On I_start=1: O_chan = (I_mode ? 0 : I_chan_sel) and O_timeout clears; next state is WAIT_READY.
  - O_busy=1 from the next cycle.
  - I_start is ignored in every other state, including the DONE cycle.
- WAIT_READY: if I_ready[O_chan]=1 in cycle r, O_trigger=1 from cycle r+1.
- PRE:
  - Lasts I_trig_pre cycles (0 skips PRE).
  - O_start[O_chan] is high for exactly one cycle, at r+1+I_trig_pre.
  - I_trig_pre=0 puts the start pulse in the same cycle the trigger rises.
- START:
  - The cycle counter loads 0 in the start-pulse cycle.
  - It increments every following cycle and saturates at all-ones.
- RUN:
  - Completion cycle d is the first cycle with I_done[O_chan]=1 and I_busy[O_chan]=0.
  - The first cycle after the start pulse is excluded from this check (cores with done = ~busy).
  - In cycle d, O_cycle_count is loaded with the counter value (= d minus start cycle).
- POST:
  - O_trigger stays high through cycle d+I_trig_post and is low from d+I_trig_post+1.
  - If sweep mode and O_chan < pCHANNELS-1: O_chan increments and the sequence re-enters WAIT_READY in cycle d+I_trig_post+1.
  - Otherwise it enters DONE in that cycle.
- DONE:
  - O_done=1 for one cycle, then IDLE.
  - O_busy is low from the cycle after DONE.
- Timeout:
  - A per-state counter clears on entry to WAIT_READY and RUN.
  - If I_timeout != 0 and the state has lasted I_timeout cycles without progress: O_timeout is set, O_trigger drops the next cycle, remaining sweep channels are skipped, and the sequence goes to DONE (O_done still pulses).
  - O_cycle_count is not updated on timeout.
- Abort:
  - I_abort=1 in any non-IDLE state: IDLE next cycle; O_trigger, O_busy and O_start go to 0; no O_done pulse.
  - O_timeout and O_cycle_count keep their values.
- Simultaneous events (priority): abort > timeout > completion.
  - Timeout and completion in the same cycle count as completion only if the timeout limit is not yet reached.
- O_start is only ever one-hot or zero; it is never asserted outside START.

Test Plan:
- Single mode, chan 1, pre=0, post=0, timeout=0; core ready, done 10 cycles after start -> O_start=2'b10 once, trigger rises with start, O_cycle_count=10, trigger falls the cycle after done, O_done pulses once.
- pre=3, post=5 -> O_start 3 cycles after trigger rise; trigger high for exactly 3+10+1+5 cycles.
- Sweep mode, pSEL_WIDTH=1, done latencies 7 and 12 -> starts on ch0 then ch1, two trigger windows, O_cycle_count=12, O_chan=1, one O_done.
- I_ready held low, timeout=20 -> O_timeout=1 after 20 cycles in WAIT_READY, no O_start, O_done pulses; next I_start clears O_timeout.
- I_abort during RUN, together with I_done -> IDLE, no O_done, O_cycle_count unchanged; reset_i asserted mid-RUN -> all outputs 0 immediately.
- I_start repeated while O_busy=1 and during the DONE cycle -> ignored; I_start the cycle after O_done -> accepted.
